// File: rtl/seg_pkg.sv
// Shared types and constants for the scanned 7-segment display driver.
// Glyphs are active-low, bit order g..a.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    LATCH
  } state_e;

  localparam int BCD_DIGITS = 5;
  localparam int MAX_DISP   = 9999;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  function automatic int bcd_value(
    input logic [4*BCD_DIGITS-1:0] b
  );
    int v;
    v = 0;
    for (int i = BCD_DIGITS - 1; i >= 0; i--)
      v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 5-digit BCD converter (shift-add-3).
// One conversion takes 16 shift cycles plus one result cycle.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic        busy_o,
  output logic        valid_o,
  output logic [19:0] bcd_o
);

  state_e      state_q, state_d;
  logic [35:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [35:0] adj;

  always_comb begin
    adj = sr_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (sr_q[16+4*i +: 4] >= 4'd5)
        adj[16+4*i +: 4] = sr_q[16+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          sr_d    = {20'b0, bin_i};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        sr_d  = {adj[34:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15)
          state_d = LATCH;
      end
      LATCH: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o  = busy_q;
  assign valid_o = (state_q == LATCH);
  assign bcd_o   = sr_q[35:16];

endmodule

// File: rtl/seg_scan_display_seq.sv
// Captures divider quotient, converts to BCD, scans 4 active-low digits.
// Option LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_scan_display_seq
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [DATA_W-1:0] y,
  output logic              busy,
  output logic              ovf,
  output logic [6:0]        out,
  output logic              led1,
  output logic              led2,
  output logic              led3,
  output logic              led4
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic              done_q;
  logic              start_q;
  logic [DATA_W-1:0] y_q;
  logic              bcd_vld;
  logic [19:0]       bcd;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic          ovf_q, ovf_d;
  logic [6:0]    out_q, out_d;
  logic [3:0]    led_q;
  logic [3:0]    dig;
  logic          blank;

  // Edge detect costs one cycle; the start pulse is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q  <= 1'b0;
      start_q <= 1'b0;
      y_q     <= '0;
    end else begin
      done_q  <= done;
      start_q <= done & ~done_q;
      if (done & ~done_q)
        y_q <= y;
    end
  end

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (start_q),
    .bin_i   (y_q),
    .busy_o  (busy),
    .valid_o (bcd_vld),
    .bcd_o   (bcd)
  );

  always_comb begin
    cnt_d  = (cnt_q == SCAN_LAST) ? '0 : cnt_q + 1'b1;
    idx_d  = (cnt_q == SCAN_LAST) ? idx_q + 2'd1 : idx_q;
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (bcd_vld) begin
      ovf_d = bcd_value(bcd) > MAX_DISP;
      if (!ovf_d)
        disp_d = bcd[15:0];
    end
  end

  // Segments are computed from next-state so out and leds move together.
  always_comb begin
    dig   = disp_d[4*idx_d +: 4];
    blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    unique case (idx_d)
      2'd3:    blank = (disp_d[15:12] == 4'd0);
      2'd2:    blank = (disp_d[15:8] == 8'd0);
      2'd1:    blank = (disp_d[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
`endif
    if (ovf_d)
      out_d = SEG_DASH;
    else if (blank)
      out_d = SEG_BLANK;
    else
      out_d = seg_glyph(dig);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
      ovf_q  <= 1'b0;
      out_q  <= SEG_0;
      led_q  <= 4'b1110;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      disp_q <= disp_d;
      ovf_q  <= ovf_d;
      out_q  <= out_d;
      led_q  <= ~(4'b0001 << idx_d);
    end
  end

  assign ovf  = ovf_q;
  assign out  = out_q;
  assign led1 = led_q[0];
  assign led2 = led_q[1];
  assign led3 = led_q[2];
  assign led4 = led_q[3];

endmodule

// File: tb/tb_seg_scan_display_seq.sv
// Self-checking bench for seg_scan_display_seq (SCAN_DIV=4).
// Timing/value reference model plus a table of hand-computed glyphs.
module tb_seg_scan_display_seq;

  localparam int SD = 4;

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic        done = 1'b0;
  logic [15:0] y    = '0;
  logic        busy, ovf;
  logic [6:0]  out;
  logic        led1, led2, led3, led4;

  seg_scan_display_seq #(.SCAN_DIV(SD), .DATA_W(16)) dut (
    .clk  (clk),
    .rst  (rst),
    .done (done),
    .y    (y),
    .busy (busy),
    .ovf  (ovf),
    .out  (out),
    .led1 (led1),
    .led2 (led2),
    .led3 (led3),
    .led4 (led4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  localparam logic [6:0] GLYPH [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  // Reference model: edges since reset, pending-conversion countdown.
  int unsigned n_edges = 0;
  int unsigned pend    = 0;
  int unsigned cap_y   = 0;
  int unsigned m_val   = 0;
  bit          m_ovf   = 1'b0;
  bit          done_prev = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      n_edges = 0;
      pend = 0;
      m_val = 0;
      m_ovf = 1'b0;
      done_prev = 1'b0;
    end else begin : mdl
      bit rise;
      int unsigned was;
      rise = done && !done_prev;
      was = pend;
      n_edges++;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_ovf = (cap_y > 9999);
          if (!m_ovf) m_val = cap_y;
        end
      end
      if (rise && was <= 1) begin
        pend = 18;
        cap_y = y;
      end
      done_prev = done;
    end
  end

  function automatic logic [6:0] exp_glyph(int i);
    int unsigned pw;
    pw = 1;
    for (int k = 0; k < i; k++) pw = pw * 10;
    if (m_ovf) return 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
    if (i > 0 && m_val < pw) return 7'h7F;
`endif
    return GLYPH[(m_val / pw) % 10];
  endfunction

  function automatic logic [11:0] expect_vec();
    int  idx;
    bit  b;
    logic [3:0] l;
    idx = int'((n_edges / SD) % 4);
    b = (pend >= 1 && pend <= 17);
    l = ~(4'b0001 << idx);
    return {b, m_ovf, exp_glyph(idx), l};
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin : chk
      logic [11:0] act, exp;
      act = {busy, ovf, out, led4, led3, led2, led1};
      exp = expect_vec();
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model t=%0t got busy=%b ovf=%b out=%h led=%b want busy=%b ovf=%b out=%h led=%b",
          $time, act[11], act[10], act[9:4], act[3:0],
          exp[11], exp[10], exp[9:4], exp[3:0]);
      end
      checks++;
      if ($countones({led4, led3, led2, led1}) != 3) begin
        errors++;
        $display("FAIL onehot t=%0t got led=%b want exactly one low",
          $time, {led4, led3, led2, led1});
      end
    end
  end

  typedef struct packed {
    logic [15:0] y;
    logic        ovf;
    logic [27:0] g;
  } vec_t;

  vec_t vt [8];

  task automatic pulse(input logic [15:0] v, input int w);
    @(posedge clk);
    #1;
    y = v;
    done = 1'b1;
    repeat (w) @(posedge clk);
    #1;
    done = 1'b0;
  endtask

  task automatic check_glyphs(input vec_t v, input string nm);
    int idx;
    logic [6:0] g;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      case ({led4, led3, led2, led1})
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      checks++;
      if (idx < 0) begin
        errors++;
        $display("FAIL %s leds got %b want one low", nm,
          {led4, led3, led2, led1});
      end else begin
        g = v.g[7*idx +: 7];
        if (out !== g || ovf !== v.ovf) begin
          errors++;
          $display("FAIL %s digit%0d got out=%h ovf=%b want out=%h ovf=%b",
            nm, idx, out, ovf, g, v.ovf);
        end
      end
    end
  endtask

  initial begin
    int bc;
    vec_t v;
    vt[0] = '{16'd1234,  1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
    vt[1] = '{16'd65535, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vt[2] = '{16'd9999,  1'b0, {7'h10, 7'h10, 7'h10, 7'h10}};
    vt[3] = '{16'd10000, 1'b1, {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vt[4] = '{16'd1005,  1'b0, {7'h79, 7'h40, 7'h40, 7'h12}};
`ifdef LEADING_ZERO_BLANK_EN
    vt[5] = '{16'd7,     1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
    vt[6] = '{16'd500,   1'b0, {7'h7F, 7'h12, 7'h40, 7'h40}};
    vt[7] = '{16'd0,     1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
`else
    vt[5] = '{16'd7,     1'b0, {7'h40, 7'h40, 7'h40, 7'h78}};
    vt[6] = '{16'd500,   1'b0, {7'h40, 7'h12, 7'h40, 7'h40}};
    vt[7] = '{16'd0,     1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
`endif

    #2 rst = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    @(negedge clk);
    checks++;
    if ({busy, ovf, out, led4, led3, led2, led1} !== {2'b00, 7'h40, 4'b1110}) begin
      errors++;
      $display("FAIL reset got busy=%b ovf=%b out=%h led=%b want 0 0 40 1110",
        busy, ovf, out, {led4, led3, led2, led1});
    end

    // done held high: busy for exactly 17 cycles, no retrigger
    @(posedge clk);
    #1;
    y = 16'd1234;
    done = 1'b1;
    bc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    checks++;
    if (bc != 17) begin
      errors++;
      $display("FAIL busy_len got %0d want 17", bc);
    end
    check_glyphs(vt[0], "hold_1234");
    done = 1'b0;

    for (int i = 0; i < 8; i++) begin
      pulse(vt[i].y, 1);
      repeat (20) @(posedge clk);
      check_glyphs(vt[i], $sformatf("table%0d", i));
    end

    // second edge mid-conversion is dropped
    pulse(16'd9999, 1);
    repeat (5) @(posedge clk);
    pulse(16'd5, 1);
    repeat (25) @(posedge clk);
    check_glyphs(vt[2], "drop_second");

    // reset during the 8th conversion cycle
    pulse(16'd500, 1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({busy, ovf, out, led4, led3, led2, led1} !== {2'b00, 7'h40, 4'b1110}) begin
      errors++;
      $display("FAIL mid_reset got busy=%b ovf=%b out=%h led=%b want 0 0 40 1110",
        busy, ovf, out, {led4, led3, led2, led1});
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    pulse(16'd500, 1);
    repeat (20) @(posedge clk);
    check_glyphs(vt[6], "after_reset");

    // randomized traffic against the model
    for (int i = 0; i < 30; i++) begin
      v.y = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 65535))
                                        : 16'($urandom_range(0, 9999));
      pulse(v.y, int'($urandom_range(1, 20)));
      repeat ($urandom_range(0, 30)) @(posedge clk);
    end
    repeat (25) @(posedge clk);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
